// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory handshake timeout and sticky fault.
// Define MULTICYCLE_ORI_EN to make ori (001101) a legal instruction.
module multicycle_control #(
  parameter int ACW         = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [5:0]     opcode,
  input  logic [5:0]     funct,
  input  logic           mem_ready,
  input  logic           zero,
  output logic           ALUSrc,
  output logic           RegDst,
  output logic           MemWrite,
  output logic           MemRead,
  output logic           MemToReg,
  output logic           RegWrite,
  output logic [ACW-1:0] ALUControl,
  output logic           ir_load,
  output logic           pc_en,
  output logic [1:0]     pc_src,
  output logic [2:0]     state,
  output logic           fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    I_RTYPE, I_LW, I_SW, I_ADDI, I_ORI, I_BEQ, I_BNE, I_J, I_BAD
  } instr_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ORI_EN
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam int             WCW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [5:0]     op_q, op_d;
  logic [5:0]     funct_q, funct_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           fault_q, fault_d;

  instr_e         instr;
  logic [3:0]     alu_code;

  // Instruction class and ALU code come from the latched fields, never the live inputs.
  always_comb begin
    instr    = I_BAD;
    alu_code = 4'b0000;
    case (op_q)
      OP_RTYPE: begin
        instr = I_RTYPE;
        case (funct_q)
          6'b100000: alu_code = 4'b0010;
          6'b100010: alu_code = 4'b0110;
          6'b100100: alu_code = 4'b0000;
          6'b100101: alu_code = 4'b0001;
          6'b101010: alu_code = 4'b0111;
          6'b000000: alu_code = 4'b1110;
          default:   instr    = I_BAD;
        endcase
      end
      OP_LW:   begin instr = I_LW;   alu_code = 4'b0010; end
      OP_SW:   begin instr = I_SW;   alu_code = 4'b0010; end
      OP_ADDI: begin instr = I_ADDI; alu_code = 4'b0010; end
      OP_BEQ:  begin instr = I_BEQ;  alu_code = 4'b0110; end
      OP_BNE:  begin instr = I_BNE;  alu_code = 4'b0110; end
      OP_J:    instr = I_J;
`ifdef MULTICYCLE_ORI_EN
      OP_ORI:  begin instr = I_ORI;  alu_code = 4'b0001; end
`endif
      default: instr = I_BAD;
    endcase
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    wait_d     = '0;
    fault_d    = fault_q;
    ALUSrc     = 1'b0;
    RegDst     = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUControl = '0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_en   = 1'b1;
          op_d    = opcode;
          funct_d = funct;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_DECODE: begin
        case (instr)
          I_RTYPE, I_LW, I_SW, I_ADDI, I_ORI: state_d = S_EXEC;
          I_BEQ, I_BNE:                       state_d = S_BRANCH;
          I_J:                                state_d = S_JUMP;
          default: begin
            fault_d = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        ALUControl = ACW'(alu_code);
        ALUSrc     = instr inside {I_LW, I_SW, I_ADDI, I_ORI};
        state_d    = (instr inside {I_LW, I_SW}) ? S_MEM : S_WB;
      end
      S_MEM: begin
        MemRead  = (instr == I_LW);
        MemWrite = (instr == I_SW);
        if (mem_ready) begin
          state_d = (instr == I_LW) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (instr == I_RTYPE);
        MemToReg = (instr == I_LW);
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUControl = ACW'(alu_code);
        pc_src     = 2'b01;
        pc_en      = ((instr == I_BEQ) & zero) | ((instr == I_BNE) & ~zero);
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_en   = 1'b1;
        pc_src  = 2'b10;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected traces built from instruction rules,
// a negedge compare process, and literal checks on selected traces.
module tb_multicycle_control;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset, mem_ready, zero;
  logic [5:0] opcode, funct;
  logic       ALUSrc, RegDst, MemWrite, MemRead, MemToReg, RegWrite, ir_load, pc_en, fault;
  logic [3:0] ALUControl;
  logic [1:0] pc_src;
  logic [2:0] state;

  multicycle_control #(.ACW(4), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero),
    .ALUSrc(ALUSrc), .RegDst(RegDst), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       alusrc, regdst, memwrite, memread, memtoreg, regwrite, irload, pcen;
    logic [1:0] pcsrc;
    logic [3:0] aluc;
    logic       flt;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op, fn;
    logic       rdy, z, chk;
    outs_t      e;
  } cyc_t;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_ORI = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_BAD = 8;

  cyc_t  vq[$];
  outs_t obs[$];
  cyc_t  cur;
  bit    cur_valid = 1'b0;
  logic  model_fault = 1'b0;
  int    n_cyc = 0;
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                   output int k, output logic [3:0] a);
    k = K_BAD;
    a = 4'h0;
    case (op)
      6'b000000: case (fn)
        6'b100000: begin k = K_R; a = 4'b0010; end
        6'b100010: begin k = K_R; a = 4'b0110; end
        6'b100100: begin k = K_R; a = 4'b0000; end
        6'b100101: begin k = K_R; a = 4'b0001; end
        6'b101010: begin k = K_R; a = 4'b0111; end
        6'b000000: begin k = K_R; a = 4'b1110; end
        default: ;
      endcase
      6'b100011: begin k = K_LW;   a = 4'b0010; end
      6'b101011: begin k = K_SW;   a = 4'b0010; end
      6'b001000: begin k = K_ADDI; a = 4'b0010; end
      6'b000100: begin k = K_BEQ;  a = 4'b0110; end
      6'b000101: begin k = K_BNE;  a = 4'b0110; end
      6'b000010: k = K_J;
`ifdef MULTICYCLE_ORI_EN
      6'b001101: begin k = K_ORI;  a = 4'b0001; end
`endif
      default: ;
    endcase
  endfunction

  // Idle-cycle template: junk opcode/funct and mem_ready high, which the DUT must ignore.
  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c.rst = 1'b0; c.op = 6'h3f; c.fn = 6'h3f; c.rdy = 1'b1; c.z = 1'b0; c.chk = 1'b1;
    c.e = '0;
    c.e.st  = st;
    c.e.flt = model_fault;
    return c;
  endfunction

  task automatic gen_reset();
    cyc_t c;
    c = blank(3'd0);
    c.rst = 1'b1; c.rdy = 1'b0; c.chk = 1'b0;
    vq.push_back(c);
    model_fault = 1'b0;
  endtask

  task automatic gen_fetch_timeout();
    cyc_t c;
    for (int i = 0; i < TMO; i++) begin
      c = blank(3'd0); c.rdy = 1'b0; c.e.memread = 1'b1; vq.push_back(c);
    end
    model_fault = 1'b1;
  endtask

  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fwait, input int mwait, input bit cut);
    int k;
    logic [3:0] a;
    cyc_t c;
    classify(op, fn, k, a);
    for (int i = 0; i < fwait; i++) begin
      c = blank(3'd0); c.rdy = 1'b0; c.e.memread = 1'b1; vq.push_back(c);
    end
    c = blank(3'd0);
    c.op = op; c.fn = fn;
    c.e.memread = 1'b1; c.e.irload = 1'b1; c.e.pcen = 1'b1;
    vq.push_back(c);
    vq.push_back(blank(3'd1));
    case (k)
      K_BAD: model_fault = 1'b1;
      K_BEQ, K_BNE: begin
        c = blank(3'd5); c.z = z; c.e.aluc = a; c.e.pcsrc = 2'b01;
        c.e.pcen = (k == K_BEQ) ? z : !z;
        vq.push_back(c);
      end
      K_J: begin
        c = blank(3'd6); c.e.pcen = 1'b1; c.e.pcsrc = 2'b10; vq.push_back(c);
      end
      default: begin
        c = blank(3'd2); c.e.aluc = a; c.e.alusrc = (k != K_R); vq.push_back(c);
        if (k == K_LW || k == K_SW) begin
          for (int i = 0; i < mwait && i < TMO; i++) begin
            c = blank(3'd3); c.rdy = 1'b0;
            c.e.memread = (k == K_LW); c.e.memwrite = (k == K_SW);
            vq.push_back(c);
          end
          if (cut) return;
          if (mwait >= TMO) begin
            model_fault = 1'b1;
            return;
          end
          c = blank(3'd3); c.e.memread = (k == K_LW); c.e.memwrite = (k == K_SW);
          vq.push_back(c);
        end
        if (k != K_SW) begin
          c = blank(3'd4); c.e.regwrite = 1'b1;
          c.e.regdst = (k == K_R); c.e.memtoreg = (k == K_LW);
          vq.push_back(c);
        end
      end
    endcase
  endtask

  task automatic run();
    while (vq.size() > 0) begin
      @(posedge clk);
      #1;
      cur       = vq.pop_front();
      reset     = cur.rst;
      opcode    = cur.op;
      funct     = cur.fn;
      mem_ready = cur.rdy;
      zero      = cur.z;
      n_cyc++;
      cur_valid = 1'b1;
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    outs_t got;
    if (cur_valid) begin
      got = {state, ALUSrc, RegDst, MemWrite, MemRead, MemToReg, RegWrite,
             ir_load, pc_en, pc_src, ALUControl, fault};
      obs.push_back(got);
      if (cur.chk) check($sformatf("cycle %0d outputs", n_cyc), 32'(got), 32'(cur.e));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt;
    reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; zero = 1'b0;
    gen_reset(); gen_reset(); run();

    base = obs.size();
    gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
    check("model add length", vq.size(), 4);
    run();
    check("add state trace", 32'({obs[base].st, obs[base+1].st, obs[base+2].st, obs[base+3].st}),
          32'({3'd0, 3'd1, 3'd2, 3'd4}));
    check("add ALUControl in EXEC", obs[base+2].aluc, 4'b0010);
    check("add RegWrite/RegDst in WB", {obs[base+3].regwrite, obs[base+3].regdst}, 2'b11);
    cnt = 0;
    for (int i = base; i < obs.size(); i++) if (obs[i].regwrite || obs[i].regdst) cnt++;
    check("add RegWrite cycles", cnt, 1);

    gen_instr(6'b000000, 6'b100010, 1'b0, 2, 0, 1'b0);
    gen_instr(6'b000000, 6'b100100, 1'b0, 0, 0, 1'b0);
    gen_instr(6'b000000, 6'b100101, 1'b0, 1, 0, 1'b0);
    gen_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 1'b0);
    gen_instr(6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0);
    gen_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b0);
    gen_instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1'b0);
    run();

    base = obs.size();
    gen_instr(6'b100011, 6'b000000, 1'b0, 1, 3, 1'b0);
    check("model lw length", vq.size(), 9);
    run();
    cnt = 0;
    for (int i = base; i < obs.size(); i++) if (obs[i].st == 3'd3 && obs[i].memread) cnt++;
    check("lw MemRead held in MEM", cnt, 4);
    check("lw WB MemToReg", {obs[obs.size()-1].st, obs[obs.size()-1].memtoreg}, {3'd4, 1'b1});
    check("lw fault", obs[obs.size()-1].flt, 1'b0);

    base = obs.size();
    gen_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);
    check("model beq length", vq.size(), 3);
    gen_instr(6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0);
    run();
    check("beq taken pc_en/pc_src", {obs[base+2].pcen, obs[base+2].pcsrc}, 3'b101);
    check("bne zero=1 pc_en", obs[base+5].pcen, 1'b0);
    gen_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0);
    gen_instr(6'b000101, 6'b000000, 1'b0, 0, 0, 1'b0);
    gen_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);
    run();

    base = obs.size();
    gen_instr(6'b101011, 6'b000000, 1'b0, 0, TMO, 1'b0);
    gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
    run();
    cnt = 0;
    for (int i = base; i < obs.size(); i++) if (obs[i].st == 3'd3) cnt++;
    check("sw timeout MEM cycles", cnt, TMO);
    check("sw timeout then FETCH with fault", {obs[base+3+TMO].st, obs[base+3+TMO].flt}, {3'd0, 1'b1});
    cnt = 0;
    for (int i = base; i < base + 3 + TMO; i++) if (obs[i].regwrite) cnt++;
    check("sw timeout RegWrite", cnt, 0);
    gen_reset(); run();

    base = obs.size();
    gen_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
    gen_reset();
    gen_instr(6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0);
    run();
    check("illegal op DECODE->FETCH", 32'({obs[base+1].st, obs[base+2].st}), 32'({3'd1, 3'd0}));
    check("illegal op fault", obs[base+2].flt, 1'b1);
    check("reset clears fault", obs[base+3].flt, 1'b0);

    base = obs.size();
    gen_instr(6'b000000, 6'b111111, 1'b0, 0, 0, 1'b0);
    gen_reset();
    run();
    check("illegal funct fault", {obs[base+2].st, obs[base+2].flt}, {3'd0, 1'b1});

    base = obs.size();
    gen_instr(6'b001101, 6'b000000, 1'b0, 0, 0, 1'b0);
    gen_reset();
    run();
`ifdef MULTICYCLE_ORI_EN
    check("ori EXEC ALUControl/ALUSrc", {obs[base+2].aluc, obs[base+2].alusrc}, {4'b0001, 1'b1});
    check("ori WB RegWrite", {obs[base+3].st, obs[base+3].regwrite, obs[base+3].regdst}, {3'd4, 2'b10});
`else
    check("ori disabled fault", {obs[base+2].st, obs[base+2].flt}, {3'd0, 1'b1});
`endif

    base = obs.size();
    gen_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1);
    gen_reset();
    gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
    run();
    check("mid-MEM write held before reset", {obs[base+5].st, obs[base+5].memwrite}, {3'd3, 1'b1});
    check("reset mid-MEM drops MemWrite",
          {obs[base+6].st, obs[base+6].memwrite, obs[base+6].memread, obs[base+6].regwrite},
          {3'd0, 3'b010});

    base = obs.size();
    gen_fetch_timeout();
    gen_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b0);
    run();
    check("fetch timeout fault", {obs[base+TMO].st, obs[base+TMO].flt}, {3'd0, 1'b1});
    gen_reset();
    gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
    run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
